// File: rtl/cubic_inv_solver.sv
// cubic_inv_solver: bisection inverse of fq(x) = ((COEF*x^3) >>> SHIFT) + BIAS, one x bit per cycle.
// Optional macro ROUND_NEAREST_EN adds a ROUND state that picks the nearer of x and x+1.
module cubic_inv_solver #(
    parameter int WIDTH = 10,
    parameter int COEF  = 218,
    parameter int SHIFT = 23,
    parameter int BIAS  = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] y_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] x_out,
    output logic             busy
);
    // state  | meaning
    // IDLE   | waiting for y_in
    // SEARCH | one trial bit of the offset code per cycle, MSB first
    // ROUND  | nearest-rounding step (ROUND_NEAREST_EN only)
    // DONE   | x_out valid, held until out_ready
    localparam int X3W = 3 * WIDTH - 2;
    localparam int PW  = X3W + 8;
    localparam int KW  = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MSB = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic signed [PW-1:0] COEF_W = PW'(COEF);
    localparam logic signed [PW-1:0] BIAS_W = PW'(BIAS);

    typedef enum logic [1:0] {S_IDLE, S_SEARCH, S_ROUND, S_DONE} state_t;

    function automatic logic signed [PW-1:0] fq(input logic [WIDTH-1:0] x);
        logic signed [X3W-1:0] xe;
        logic signed [X3W-1:0] c3;
        logic signed [PW-1:0]  x3;
        logic signed [PW-1:0]  p;
        xe = {{(X3W-WIDTH){x[WIDTH-1]}}, x};
        c3 = xe * xe * xe;
        x3 = {{(PW-X3W){c3[X3W-1]}}, c3};
        p  = COEF_W * x3;
        return (p >>> SHIFT) + BIAS_W;
    endfunction

    state_t                r_state;
    logic signed [PW-1:0]  r_y;
    logic [WIDTH-1:0]      r_u;
    logic [KW-1:0]         r_k;
    logic [WIDTH-1:0]      r_x_out;
    logic                  r_in_ready;
    logic                  r_out_valid;
    logic                  r_busy;

    logic [WIDTH-1:0]      w_t;
    logic [WIDTH-1:0]      w_u_next;
    logic                  w_le;

    // Trial code t is an offset code; flipping the MSB gives the signed x.
    assign w_t      = r_u | (ONE << r_k);
    assign w_le     = (fq(w_t ^ MSB) <= r_y);
    assign w_u_next = w_le ? w_t : r_u;

`ifdef ROUND_NEAREST_EN
    localparam logic [WIDTH-1:0] MAXX = ~MSB;
    logic signed [PW-1:0]  w_d0;
    logic signed [PW-1:0]  w_d1;
    logic signed [PW-1:0]  w_a0;
    logic signed [PW-1:0]  w_a1;
    logic                  w_up;

    assign w_d0 = r_y - fq(r_x_out);
    assign w_d1 = fq(r_x_out + ONE) - r_y;
    assign w_a0 = w_d0[PW-1] ? -w_d0 : w_d0;
    assign w_a1 = w_d1[PW-1] ? -w_d1 : w_d1;
    assign w_up = (r_x_out != MAXX) && (w_a1 < w_a0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_y         <= '0;
            r_u         <= '0;
            r_k         <= '0;
            r_x_out     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid && r_in_ready) begin
                        r_y        <= {{(PW-WIDTH){y_in[WIDTH-1]}}, y_in};
                        r_u        <= '0;
                        r_k        <= KW'(WIDTH - 1);
                        r_state    <= S_SEARCH;
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end
                S_SEARCH: begin
                    r_u <= w_u_next;
                    r_k <= r_k - KW'(1);
                    if (r_k == '0) begin
                        r_x_out <= w_u_next ^ MSB;
`ifdef ROUND_NEAREST_EN
                        r_state <= S_ROUND;
`else
                        r_state     <= S_DONE;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
`endif
                    end
                end
`ifdef ROUND_NEAREST_EN
                S_ROUND: begin
                    if (w_up) begin
                        r_x_out <= r_x_out + ONE;
                    end
                    r_state     <= S_DONE;
                    r_busy      <= 1'b0;
                    r_out_valid <= 1'b1;
                end
`endif
                S_DONE: begin
                    if (out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign busy      = r_busy;
    assign x_out     = r_x_out;
endmodule

// File: tb/tb_cubic_inv_solver.sv
// tb_cubic_inv_solver: table vectors, back-pressure, mid-search reset and a full y sweep
// against a brute-force model; build with ROUND_NEAREST_EN to check the rounded variant.
module tb_cubic_inv_solver;
`ifdef ROUND_NEAREST_EN
    localparam int LAT = 11;
    localparam bit RND = 1'b1;
`else
    localparam int LAT = 10;
    localparam bit RND = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [9:0] y_in = '0;
    logic       in_ready;
    logic       out_valid;
    logic       busy;
    logic [9:0] x_out;

    int         n_checks = 0;
    int         n_err = 0;
    logic [9:0] exp_q[$];

    typedef struct {
        logic [9:0] y;
        logic [9:0] x;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    cubic_inv_solver dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .y_in     (y_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .x_out    (x_out),
        .busy     (busy)
    );

    function automatic longint fq_ref(input int x);
        longint p;
        longint q;
        p = 218 * longint'(x) * x * x;
        q = p / 8388608;
        if (p < 0 && q * 8388608 != p) q = q - 1;
        return q + 64;
    endfunction

    function automatic logic [9:0] solve_ref(input int y);
        int     best;
        longint a0;
        longint a1;
        best = -512;
        for (int x = -512; x <= 511; x++)
            if (fq_ref(x) <= y) best = x;
        if (RND && best < 511) begin
            a0 = y - fq_ref(best);
            a1 = fq_ref(best + 1) - y;
            if (a0 < 0) a0 = -a0;
            if (a1 < 0) a1 = -a1;
            if (a1 < a0) best = best + 1;
        end
        return 10'(best);
    endfunction

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_output", 1, 0);
            else check("x_out", x_out, exp_q.pop_front());
        end
    end

    // Called and returns at posedge+1; returns once out_valid is seen.
    task automatic send(input logic [9:0] y, input logic [9:0] exp);
        int n;
        int bad;
        n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            check("in_ready_timeout", 0, 1);
            return;
        end
        y_in = y;
        in_valid = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        bad = 0;
        while (!out_valid && n < 50) begin
            if (in_ready || !busy) bad++;
            @(posedge clk); #1;
            n++;
        end
        check("latency", n, LAT);
        check("busy_in_ready_during_solve", bad, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0] snap;
        int         bad;
        int         n;

        // fq is flat at 64 for x in [0,33], so y=64 resolves to 33.
        vecs[0] = '{y: 10'd64,  x: 10'h021};
        vecs[1] = '{y: 10'd118, x: 10'h080};
        vecs[2] = '{y: 10'd117, x: 10'h07F};
`ifdef ROUND_NEAREST_EN
        vecs[3] = '{y: 10'h204, x: 10'h2E8};
`else
        vecs[3] = '{y: 10'h204, x: 10'h2E7};
`endif
        vecs[4] = '{y: 10'h1FF, x: 10'h102};
        vecs[5] = '{y: 10'h200, x: 10'h2E7};

        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_x_out", x_out, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 6; i++) send(vecs[i].y, vecs[i].x);

        // Back-pressure: hold DONE with in_valid asserted the whole time.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(10'd117, 10'h07F);
        snap = x_out;
        y_in = 10'h2D4;
        in_valid = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            if (!out_valid || x_out != snap || in_ready || busy) bad++;
            @(posedge clk); #1;
        end
        check("backpressure_hold", bad, 0);
        check("backpressure_x_out", snap, 10'h07F);
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("exit_in_ready", in_ready, 1);
        @(posedge clk); #1;
        check("no_accept_on_exit", busy, 0);
        check("queue_after_backpressure", exp_q.size(), 0);

        // Asynchronous reset in the middle of a search.
        y_in = 10'd64;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        check("pre_reset_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_out_valid", out_valid, 0);
        check("midrst_x_out", x_out, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midrst_in_ready", in_ready, 1);
        bad = 0;
        for (int c = 0; c < 15; c++) begin
            if (out_valid || busy) bad++;
            @(posedge clk); #1;
        end
        check("midrst_no_output", bad, 0);
        send(10'd117, 10'h07F);

        for (int y = -512; y <= 511; y++) send(10'(y), solve_ref(y));

        n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("queue_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
